// File: rtl/countdown_timer.sv
// Loadable down-counter timer with start/stop control and a one-cycle terminal-count pulse.
// Optional auto-reload mode (port auto_rld_i) is enabled by defining COUNTDOWN_TIMER_AUTORELOAD_EN.
module countdown_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_cnt_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             ena_cnt_i,
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  input  logic             auto_rld_i,
`endif
  output logic [WIDTH-1:0] cnt_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [1:0]       state_r;
  logic [1:0]       state_s;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_s;
  logic             tc_r;
  logic             tc_s;
  logic             busy_r;
  logic             done_r;
  logic             auto_s;

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
  assign auto_s = auto_rld_i;
`else
  assign auto_s = 1'b0;
`endif

  // Next-state, next-count and terminal-pulse decode; ld > stop > start > ena.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    reload_s = reload_r;
    tc_s     = 1'b0;
    if (ld_i) begin
      cnt_s    = ld_cnt_i;
      reload_s = ld_cnt_i;
      state_s  = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (stop_i) begin
            state_s = ST_IDLE;
          end else if (start_i) begin
            if (cnt_r != CNT_ZERO) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_DONE;
              tc_s    = 1'b1;
            end
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            state_s = ST_IDLE;
          end else if (ena_cnt_i) begin
            if (cnt_r > CNT_ONE) begin
              cnt_s = cnt_r - CNT_ONE;
            end else if (cnt_r == CNT_ONE) begin
              tc_s = 1'b1;
              // A zero reload cannot sustain a run, so it falls through to DONE.
              if (auto_s && (reload_r != CNT_ZERO)) begin
                cnt_s = reload_r;
              end else begin
                cnt_s   = CNT_ZERO;
                state_s = ST_DONE;
              end
            end else begin
              cnt_s = CNT_ZERO;
            end
          end else begin
            cnt_s = cnt_r;
          end
        end
        ST_DONE: begin
          if (stop_i) begin
            state_s = ST_IDLE;
          end else if (start_i) begin
            cnt_s = reload_r;
            if (reload_r != CNT_ZERO) begin
              state_s = ST_RUN;
            end else begin
              state_s = ST_DONE;
              tc_s    = 1'b1;
            end
          end else begin
            state_s = ST_DONE;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, count, reload value and registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_IDLE;
      cnt_r    <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      tc_r     <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      reload_r <= reload_s;
      tc_r     <= tc_s;
      busy_r   <= (state_s == ST_RUN);
      done_r   <= (state_s == ST_DONE);
    end
  end

  assign cnt_o  = cnt_r;
  assign busy_o = busy_r;
  assign tc_o   = tc_r;
  assign done_o = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table through a scoreboard queue,
// plus hand sequences for max load, async reset and (when enabled) auto-reload.
module tb_countdown_timer;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       ld_i;
  logic [7:0] ld_cnt_i;
  logic       start_i;
  logic       stop_i;
  logic       ena_cnt_i;
  logic       auto_rld_i;
  logic [7:0] cnt_o;
  logic       busy_o;
  logic       tc_o;
  logic       done_o;

  typedef struct {
    logic       ld;
    logic [7:0] ld_cnt;
    logic       start;
    logic       stop;
    logic       ena;
    logic [7:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       busy;
    logic       tc;
    logic       done;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  countdown_timer #(.WIDTH(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ld_i      (ld_i),
    .ld_cnt_i  (ld_cnt_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .ena_cnt_i (ena_cnt_i),
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    .auto_rld_i(auto_rld_i),
`endif
    .cnt_o     (cnt_o),
    .busy_o    (busy_o),
    .tc_o      (tc_o),
    .done_o    (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic add(input logic ld, input logic [7:0] ldc, input logic st, input logic sp,
                     input logic en, input logic [7:0] c, input logic b, input logic t,
                     input logic d);
    vec_t v;
    v.ld = ld; v.ld_cnt = ldc; v.start = st; v.stop = sp; v.ena = en;
    v.cnt = c; v.busy = b; v.tc = t; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] c, input logic b,
                       input logic t, input logic d);
    n_tests++;
    if (cnt_o !== c || busy_o !== b || tc_o !== t || done_o !== d) begin
      n_fail++;
      $display("FAIL %s: got cnt=%0d busy=%b tc=%b done=%b, want cnt=%0d busy=%b tc=%b done=%b",
               name, cnt_o, busy_o, tc_o, done_o, c, b, t, d);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then pop and compare after the edge.
  task automatic step(input string name, input logic ld, input logic [7:0] ldc,
                      input logic st, input logic sp, input logic en,
                      input logic [7:0] c, input logic b, input logic t, input logic d);
    exp_t e;
    @(negedge clk_i);
    ld_i = ld; ld_cnt_i = ldc; start_i = st; stop_i = sp; ena_cnt_i = en;
    e.cnt = c; e.busy = b; e.tc = t; e.done = d;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check(name, e.cnt, e.busy, e.tc, e.done);
  endtask

  initial begin
    rst_ni = 1'b0; ld_i = 1'b0; ld_cnt_i = 8'd0; start_i = 1'b0; stop_i = 1'b0;
    ena_cnt_i = 1'b0; auto_rld_i = 1'b0;
    #12;
    check("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    //  ld  ldc    st    sp    en    cnt   busy  tc    done
    // basic run
    add(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    // gaps and stop/resume
    add(1'b1, 8'd10, 1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd7, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
    // priority: ld beats stop/start/ena at cnt 6
    add(1'b1, 8'd7, 1'b0, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd6, 1'b1, 1'b0, 1'b0);
    add(1'b1, 8'd3, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
    // zero load: start goes straight to DONE, restart from DONE pulses again
    add(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
    // restart from DONE reloads, start ignored in RUN, stop from DONE
    add(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i].ld, vecs[i].ld_cnt, vecs[i].start, vecs[i].stop,
           vecs[i].ena, vecs[i].cnt, vecs[i].busy, vecs[i].tc, vecs[i].done);
    end

    // Max load takes 255 ticks and never wraps
    step("max_ld", 1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0);
    step("max_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 255; k++) begin
      step("max_tick", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'(255 - k), 1'b1, 1'b0, 1'b0);
    end
    step("max_tc", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
    step("max_hold", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-RUN at cnt 9 clears everything without waiting for an edge
    step("rst_ld", 1'b1, 8'd9, 1'b0, 1'b0, 1'b0, 8'd9, 1'b0, 1'b0, 1'b0);
    step("rst_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd9, 1'b1, 1'b0, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_async", 8'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    check("rst_held", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    step("post_rst_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    auto_rld_i = 1'b1;
    step("ar_ld", 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    step("ar_start", 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0);
    step("ar_t1", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    step("ar_t2", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    step("ar_t3", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
    step("ar_t4", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    step("ar_t5", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    step("ar_t6", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
    auto_rld_i = 1'b0;
    step("ar_off_t1", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
    step("ar_off_t2", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
    step("ar_off_t3", 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
